// File: rtl/ram_bist.sv
// March-style BIST engine for a single-port synchronous RAM.
// Writes P(a) and then ~P(a), reading each pass back, and records the first failure.
module ram_bist #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {S_IDLE, S_WR0, S_RD0, S_WR1, S_RD1, S_DONE} state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 2;
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DEPTH + RD_LAT - 1);
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(DEPTH);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] seed_reg;
  logic              issue, is_rd, desc, inv;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_pat;
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    is_rd      = 1'b0;
    desc       = 1'b0;
    inv        = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_WR0;
      S_WR0: begin
        issue = 1'b1;
        if (cnt == WR_LAST) next_state = S_RD0;
      end
      S_RD0: begin
        is_rd = 1'b1;
        issue = (cnt < ISSUE_END);
        if (cnt == RD_LAST) next_state = S_WR1;
      end
      S_WR1: begin
        issue = 1'b1;
        inv   = 1'b1;
        if (cnt == WR_LAST) next_state = S_RD1;
      end
      S_RD1: begin
        is_rd = 1'b1;
        desc  = 1'b1;
        inv   = 1'b1;
        issue = (cnt < ISSUE_END);
        if (cnt == RD_LAST) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Descending order is MAX - cnt, which for a power-of-two depth is just ~cnt.
  assign cur_addr = desc ? ~cnt[ADDR_W-1:0] : cnt[ADDR_W-1:0];
  assign cur_pat  = (seed_reg ^ DATA_W'(cur_addr)) ^ {DATA_W{inv}};

  assign ram_write_enable = issue & ~is_rd;
  assign ram_address      = issue ? cur_addr : '0;
  assign ram_data_in      = ram_write_enable ? cur_pat : '0;
  assign busy             = (state != S_IDLE) && (state != S_DONE);

  // Expected data and address travel alongside the RAM read latency.
  generate
    if (RD_LAT == 0) begin : g_nopipe
      assign cmp_vld  = issue & is_rd;
      assign cmp_exp  = cur_pat;
      assign cmp_addr = cur_addr;
    end else begin : g_pipe
      logic              vld_q  [RD_LAT];
      logic [DATA_W-1:0] exp_q  [RD_LAT];
      logic [ADDR_W-1:0] addr_q [RD_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_LAT; i++) begin
            vld_q[i]  <= 1'b0;
            exp_q[i]  <= '0;
            addr_q[i] <= '0;
          end
        end else begin
          vld_q[0]  <= issue & is_rd;
          exp_q[0]  <= cur_pat;
          addr_q[0] <= cur_addr;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            exp_q[i]  <= exp_q[i-1];
            addr_q[i] <= addr_q[i-1];
          end
        end
      end

      assign cmp_vld  = vld_q[RD_LAT-1];
      assign cmp_exp  = exp_q[RD_LAT-1];
      assign cmp_addr = addr_q[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      seed_reg  <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || (state == S_IDLE)) cnt <= '0;
      else                                           cnt <= cnt + CNT_W'(1);

      if ((state == S_IDLE) && start) begin
        seed_reg  <= seed;
        done      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        err_count <= '0;
      end

      if ((state == S_RD1) && (next_state == S_DONE)) done <= 1'b1;

      // Only the first mismatch of a run is captured; later ones just count.
      if (cmp_vld && (ram_data_out != cmp_exp)) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr;
          fail_data <= ram_data_out;
        end
      end
    end
  end

endmodule
